// File: rtl/vector_op_scheduler.sv
// Round-robin sequencer for the shared vector unit.
// Accepts one command at a time, issues it, and returns a tagged status/cycle-count response.
module vector_op_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int MAX_N   = 128,
  parameter int TIMEOUT = 1024,
  localparam int IDW    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0][7:0]  req_opcode,
  input  logic [NUM_REQ-1:0][31:0] req_n,
  output logic                     vu_start,
  output logic [7:0]               vu_opcode,
  output logic [31:0]              vu_n,
  input  logic                     vu_done,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [1:0]               rsp_status,
  output logic [15:0]              rsp_cycles,
  output logic                     busy
);

  // state | meaning
  // IDLE  | waiting for a request; grant round-robin and accept in the same cycle
  // ISSUE | one-cycle vu_start pulse
  // WAIT  | counting cycles until vu_done or timeout
  // RESP  | holding the response until rsp_ready
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [1:0]     ST_OK      = 2'd0;
  localparam logic [1:0]     ST_BADLEN  = 2'd1;
  localparam logic [1:0]     ST_TIMEOUT = 2'd2;
  localparam logic [15:0]    TIMEOUT_C  = 16'(TIMEOUT);
  localparam logic [IDW-1:0] LAST_INIT  = IDW'(NUM_REQ - 1);

  state_t         state, state_nxt;
  logic [IDW-1:0] last_grant;
  logic [15:0]    cnt;
  logic [16:0]    cnt_inc;
  logic           grant_vld;
  logic [IDW-1:0] grant;
  logic           len_bad;
  logic           timeout_hit;
  int             idx;

  // first valid requester after last_grant, wrapping
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!grant_vld && req_valid[IDW'(idx)]) begin
        grant_vld = 1'b1;
        grant     = IDW'(idx);
      end
    end
  end

  assign len_bad     = (req_n[grant] == 32'd0) || (req_n[grant] > 32'(MAX_N));
  assign cnt_inc     = {1'b0, cnt} + 17'd1;
  assign timeout_hit = (cnt_inc == {1'b0, TIMEOUT_C});
  assign busy        = (state != IDLE);

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    vu_start  = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          // keep the accept quiet while reset is asserted
          req_ready[grant] = rst_n;
          state_nxt        = len_bad ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        vu_start  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (vu_done || timeout_hit) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= LAST_INIT;
      cnt        <= '0;
      vu_opcode  <= '0;
      vu_n       <= '0;
      rsp_id     <= '0;
      rsp_status <= ST_OK;
      rsp_cycles <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            last_grant <= grant;
            rsp_id     <= grant;
            vu_opcode  <= req_opcode[grant];
            vu_n       <= req_n[grant];
            if (len_bad) begin
              rsp_status <= ST_BADLEN;
              rsp_cycles <= '0;
            end
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          cnt <= cnt_inc[15:0];
          // done takes priority over a coincident timeout
          if (vu_done) begin
            rsp_status <= ST_OK;
            rsp_cycles <= cnt_inc[16] ? 16'hFFFF : cnt_inc[15:0];
          end else if (timeout_hit) begin
            rsp_status <= ST_TIMEOUT;
            rsp_cycles <= TIMEOUT_C;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_op_scheduler.sv
// Randomized bench for vector_op_scheduler against a transaction-level reference model.
module tb_vector_op_scheduler;
  localparam int NUM_REQ = 3;
  localparam int MAX_N   = 128;
  localparam int TIMEOUT = 8;
  localparam int IDW     = 2;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0][7:0]  req_opcode = '0;
  logic [NUM_REQ-1:0][31:0] req_n = '0;
  logic                     vu_start;
  logic [7:0]               vu_opcode;
  logic [31:0]              vu_n;
  logic                     vu_done = 1'b0;
  logic                     rsp_valid;
  logic                     rsp_ready = 1'b0;
  logic [IDW-1:0]           rsp_id;
  logic [1:0]               rsp_status;
  logic [15:0]              rsp_cycles;
  logic                     busy;

  vector_op_scheduler #(.NUM_REQ(NUM_REQ), .MAX_N(MAX_N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode), .req_n(req_n),
    .vu_start(vu_start), .vu_opcode(vu_opcode), .vu_n(vu_n), .vu_done(vu_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_status(rsp_status), .rsp_cycles(rsp_cycles), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: one outstanding command described by its event cycles
  int  cyc = 0;
  int  last_g = NUM_REQ - 1;
  bit  inflight = 1'b0;
  int  exp_start = -1, exp_rsp = 0, d_done = -1;
  int  e_status = 0, e_cycles = 0;
  logic [IDW-1:0] e_id = '0;
  logic [7:0]     e_op = '0;
  logic [31:0]    e_n = '0;
  logic [NUM_REQ-1:0] acc_mask = '0;

  // stimulus controls
  int  force_d = 0;
  int  p_ready = 100;
  bit  hold_req = 1'b1;
  bit  all_valid = 1'b0;
  bit          ov_en [NUM_REQ];
  logic [7:0]  ov_op [NUM_REQ];
  logic [31:0] ov_n  [NUM_REQ];
  bit found;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] pick_n();
    case ($urandom_range(0, 9))
      0:       return 32'd0;
      1:       return 32'(MAX_N + 1);
      2:       return 32'(MAX_N);
      3:       return $urandom | 32'h100;
      default: return 32'($urandom_range(1, MAX_N));
    endcase
  endfunction

  task automatic accept(input int g);
    int d;
    e_id     = IDW'(g);
    e_op     = req_opcode[g];
    e_n      = req_n[g];
    last_g   = g;
    inflight = 1'b1;
    acc_mask = NUM_REQ'(1) << g;
    if (e_n == 0 || e_n > MAX_N) begin
      e_status = 1; e_cycles = 0; exp_start = -1; d_done = -1; exp_rsp = cyc + 1;
    end else begin
      d = (force_d > 0) ? force_d : int'($urandom_range(1, TIMEOUT + 3));
      exp_start = cyc + 1;
      if (d <= TIMEOUT) begin
        e_status = 0; e_cycles = d; d_done = exp_start + d; exp_rsp = d_done + 1;
      end else begin
        e_status = 2; e_cycles = TIMEOUT; d_done = -1; exp_rsp = exp_start + TIMEOUT + 1;
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ov_en[i]) begin
        req_valid[i] = 1'b1; req_opcode[i] = ov_op[i]; req_n[i] = ov_n[i]; ov_en[i] = 1'b0;
      end else if (acc_mask[i] || (!hold_req && !req_valid[i])) begin
        if (hold_req) req_valid[i] = 1'b0;
        else begin
          req_valid[i]  = all_valid || ($urandom_range(0, 99) < 40);
          req_opcode[i] = 8'($urandom);
          req_n[i]      = pick_n();
        end
      end
    end
    acc_mask = '0;
    if (inflight && cyc == d_done) vu_done = 1'b1;
    else if (!inflight || cyc == exp_start || cyc >= exp_rsp) vu_done = ($urandom_range(0, 99) < 30);
    else vu_done = 1'b0;
    rsp_ready = ($urandom_range(0, 99) < p_ready);
  endtask

  task automatic do_cycle();
    bit exp_rv;
    int g;
    logic [NUM_REQ-1:0] exp_rdy;
    @(negedge clk);
    cyc++;
    check_eq("busy", 64'(busy), 64'(inflight));
    check_eq("vu_start", 64'(vu_start), 64'(inflight && cyc == exp_start));
    if (inflight && cyc == exp_start) begin
      check_eq("vu_opcode", 64'(vu_opcode), 64'(e_op));
      check_eq("vu_n", 64'(vu_n), 64'(e_n));
    end
    exp_rv = inflight && cyc >= exp_rsp;
    check_eq("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    if (exp_rv) begin
      check_eq("rsp_id", 64'(rsp_id), 64'(e_id));
      check_eq("rsp_status", 64'(rsp_status), 64'(e_status));
      check_eq("rsp_cycles", 64'(rsp_cycles), 64'(e_cycles));
    end
    drive();
    #1;
    g = -1;
    if (!inflight)
      for (int k = 1; k <= NUM_REQ; k++) begin
        int ix;
        ix = (last_g + k) % NUM_REQ;
        if (g < 0 && req_valid[ix]) g = ix;
      end
    exp_rdy = (g >= 0) ? (NUM_REQ'(1) << g) : '0;
    check_eq("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (exp_rv && rsp_ready) inflight = 1'b0;
    else if (g >= 0) accept(g);
  endtask

  task automatic send(input int r, input logic [7:0] op, input logic [31:0] n);
    ov_en[r] = 1'b1; ov_op[r] = op; ov_n[r] = n;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check_eq({tag, "_vu_start"}, 64'(vu_start), 64'd0);
    check_eq({tag, "_vu_opcode"}, 64'(vu_opcode), 64'd0);
    check_eq({tag, "_vu_n"}, 64'(vu_n), 64'd0);
    check_eq({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check_eq({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
    check_eq({tag, "_rsp_status"}, 64'(rsp_status), 64'd0);
    check_eq({tag, "_rsp_cycles"}, 64'(rsp_cycles), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) ov_en[i] = 1'b0;
    req_valid = '1;
    #1;
    check_all_zero("reset");
    req_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single command, done 5 cycles after start
    force_d = 5;
    send(0, 8'h01, 32'd16);
    repeat (12) do_cycle();

    // length boundaries
    force_d = 3;
    send(0, 8'h02, 32'd0);          repeat (6) do_cycle();
    send(0, 8'h03, 32'(MAX_N + 1)); repeat (6) do_cycle();
    send(0, 8'h04, 32'(MAX_N));     repeat (8) do_cycle();

    // timeout, then done coinciding with timeout, then a normal command
    force_d = TIMEOUT + 5;
    send(0, 8'h10, 32'd10); repeat (TIMEOUT + 6) do_cycle();
    force_d = TIMEOUT;
    send(0, 8'h11, 32'd11); repeat (TIMEOUT + 6) do_cycle();
    force_d = 2;
    send(0, 8'h12, 32'd12); repeat (8) do_cycle();

    // response backpressure with other requesters waiting
    p_ready = 0;
    send(0, 8'h20, 32'd5); send(1, 8'h21, 32'd6); send(2, 8'h22, 32'd7);
    repeat (16) do_cycle();
    p_ready = 100;
    repeat (30) do_cycle();

    // all requesters continuously valid
    hold_req = 1'b0; all_valid = 1'b1; force_d = 0;
    repeat (80) do_cycle();

    // fully random traffic
    all_valid = 1'b0; p_ready = 60;
    repeat (3000) do_cycle();

    // reset in the middle of WAIT
    hold_req = 1'b1; p_ready = 100; force_d = TIMEOUT + 5;
    send(0, 8'h5A, 32'd20);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      do_cycle();
      if (inflight && exp_start > 0 && cyc >= exp_start + 2 && cyc < exp_rsp - 1) found = 1'b1;
    end
    check_eq("reset_reached_wait", 64'(found), 64'd1);
    rst_n = 1'b0;
    vu_done = 1'b0;
    req_valid = 3'b011;
    #1;
    check_all_zero("midreset");
    inflight = 1'b0; last_g = NUM_REQ - 1; acc_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) ov_en[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    force_d = 0;
    repeat (30) do_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
